// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB encodings for the AHB-to-APB bridge: transfer types,
// response codes, size codes, bridge FSM state type and the byte-strobe helper.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } bridge_state_t;

  // Byte lanes touched by an AHB transfer on a 32-bit bus.
  // Sizes above a word are unsupported and get no lanes.
  function automatic logic [3:0] size_strobe(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      HSIZE_BYTE: return 4'b0001 << lsb;
      HSIZE_HALF: return lsb[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: return 4'b1111;
      default:    return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/apb_sel_decoder.sv
// Peripheral index decoder.
// Ports: idx (peripheral index field), valid (decode enable),
//        psel (one-hot select, all zero when !valid or out of range),
//        out_of_range (valid index beyond the last peripheral).
module apb_sel_decoder #(
  parameter int APB_SLAVES = 4,
  parameter int IDX_W      = 2
) (
  input  logic [IDX_W-1:0]      idx,
  input  logic                  valid,
  output logic [APB_SLAVES-1:0] psel,
  output logic                  out_of_range
);

  always_comb begin
    psel = '0;
    for (int i = 0; i < APB_SLAVES; i++)
      psel[i] = valid && (int'(idx) == i);
    out_of_range = valid && (int'(idx) >= APB_SLAVES);
  end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge. Each accepted NONSEQ/SEQ transfer
// becomes one APB SETUP+ACCESS transfer; APB wait states stretch HREADYOUT,
// PSLVERR / bad index / oversize transfers become a 2-cycle AHB ERROR.
// Ports: HCLK/HRESETn clock and async active-low reset; AHB slave side
//        HSEL/HADDR/HWRITE/HSIZE/HTRANS/HREADY/HWDATA in, HREADYOUT/HRESP/HRDATA out;
//        APB master side PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB out, PRDATA/PREADY/PSLVERR in.
module ahb2apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int APB_SLAVES = 4,
  parameter int SEL_LSB    = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [APB_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [3:0]            PSTRB,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int IDX_W = (APB_SLAVES > 1) ? $clog2(APB_SLAVES) : 1;

  bridge_state_t state, state_n, acc_state;
  logic [IDX_W-1:0]      idx;
  logic [APB_SLAVES-1:0] dec_psel, sel_q;
  logic                  oor, accept, take, err_req, apb_active, rd_done;
  logic [DATA_WIDTH-1:0] hrdata_q;

  // A single peripheral needs no index field: everything maps to slot 0.
  if (APB_SLAVES > 1) begin : g_idx
    assign idx = HADDR[SEL_LSB +: IDX_W];
  end else begin : g_idx_single
    assign idx = '0;
  end

  assign accept = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

  apb_sel_decoder #(.APB_SLAVES(APB_SLAVES), .IDX_W(IDX_W)) u_dec (
    .idx          (idx),
    .valid        (accept),
    .psel         (dec_psel),
    .out_of_range (oor)
  );

  // Only take a new address phase when this bridge is also ending its own
  // data phase; HREADY alone could be high while we are mid-transfer.
  assign take      = accept && HREADYOUT;
  assign err_req   = oor || (HSIZE > HSIZE_WORD);
  assign acc_state = err_req ? ST_ERR1 : (HWRITE ? ST_WDATA : ST_SETUP);

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_ERR2: state_n = take ? acc_state : ST_IDLE;
      ST_WDATA:         state_n = ST_SETUP;
      ST_SETUP:         state_n = ST_ACCESS;
      ST_ACCESS:
        if (PREADY) state_n = PSLVERR ? ST_ERR1 : (take ? acc_state : ST_IDLE);
      ST_ERR1:          state_n = ST_ERR2;
      default:          state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;
    PENABLE    = 1'b0;
    apb_active = 1'b0;
    case (state)
      ST_WDATA: HREADYOUT = 1'b0;
      ST_SETUP: begin
        HREADYOUT  = 1'b0;
        apb_active = 1'b1;
      end
      ST_ACCESS: begin
        apb_active = 1'b1;
        PENABLE    = 1'b1;
        HREADYOUT  = PREADY && !PSLVERR;
      end
      ST_ERR1: begin
        HRESP     = HRESP_ERROR;
        HREADYOUT = 1'b0;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  assign PSEL    = apb_active ? sel_q : '0;
  assign rd_done = (state == ST_ACCESS) && PREADY && !PSLVERR && !PWRITE;
  // Read data leaves in the completing cycle straight from PRDATA and is
  // held in hrdata_q afterwards.
  assign HRDATA  = rd_done ? PRDATA : hrdata_q;

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      PADDR    <= '0;
      PWRITE   <= 1'b0;
      PSTRB    <= '0;
      PWDATA   <= '0;
      sel_q    <= '0;
      hrdata_q <= '0;
    end else begin
      if (take) begin
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
        PSTRB  <= HWRITE ? size_strobe(HSIZE, HADDR[1:0]) : 4'b0000;
        sel_q  <= dec_psel;
      end
      if (state == ST_WDATA) PWDATA   <= HWDATA;
      if (rd_done)           hrdata_q <= PRDATA;
    end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge: table of single transfers against a
// small APB slave model, plus back-to-back and mid-transfer reset sequences.
module tb_ahb2apb_bridge;
  import ahb_apb_pkg::*;

  logic        HCLK, HRESETn, HSEL, HWRITE;
  logic [31:0] HADDR, HWDATA, HRDATA, PADDR, PWDATA, PRDATA;
  logic [2:0]  HSIZE, PSEL;
  logic [1:0]  HTRANS;
  logic        HREADY, HREADYOUT, HRESP, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [3:0]  PSTRB;

  int checks = 0, errors = 0;
  int stalls_cfg = 0, acc_cnt = 0;
  logic slverr_cfg = 1'b0;

  ahb2apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .APB_SLAVES(3), .SEL_LSB(12)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Bridge is the only slave on this bus.
  assign HREADY = HREADYOUT;

  // APB slave: inserts stalls_cfg wait cycles in ACCESS.
  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) acc_cnt <= 0;
    else if (PSEL != 0 && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  assign PREADY  = (PSEL != 0) && PENABLE && (acc_cnt >= stalls_cfg);
  assign PSLVERR = PREADY && slverr_cfg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stalls;
    logic        slverr;
    logic [2:0]  e_psel;
    logic [3:0]  e_strb;
    int          e_pen;
    int          e_cyc;
    int          e_resp;
  } vec_t;

  // Results of the last run_xfer.
  int          m_cyc, m_pen, m_resp;
  logic [2:0]  m_psel;
  logic [31:0] m_paddr, m_pwdata, m_hrdata;
  logic [3:0]  m_pstrb;
  logic        m_stable, m_done;

  // One AHB transfer; m_cyc counts data-phase cycles including the one
  // where HREADYOUT returns high.
  task automatic run_xfer(input vec_t v);
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_strb;
    s_addr = '0; s_wdata = '0; s_strb = '0;
    @(negedge HCLK);
    stalls_cfg = v.stalls; slverr_cfg = v.slverr; PRDATA = v.rdata;
    HSEL = 1'b1; HADDR = v.addr; HWRITE = v.wr; HSIZE = v.size; HTRANS = HTRANS_NONSEQ;
    @(posedge HCLK);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = v.wdata;
    m_cyc = 0; m_pen = 0; m_resp = 0; m_psel = '0; m_stable = 1'b1; m_done = 1'b0;
    m_paddr = '0; m_pwdata = '0; m_pstrb = '0; m_hrdata = '0;
    for (int c = 1; c <= 40 && !m_done; c++) begin
      m_cyc = c;
      m_psel |= PSEL;
      if (PENABLE) m_pen++;
      if (HRESP) m_resp++;
      if (PSEL != 0 && !PENABLE) begin
        s_addr = PADDR; s_strb = PSTRB; s_wdata = PWDATA;
      end
      if (PSEL != 0 && PENABLE) begin
        m_paddr = PADDR; m_pstrb = PSTRB; m_pwdata = PWDATA;
        if (PADDR !== s_addr || PSTRB !== s_strb || PWDATA !== s_wdata) m_stable = 1'b0;
      end
      if (HREADYOUT) begin
        m_done = 1'b1; m_hrdata = HRDATA;
      end else @(negedge HCLK);
    end
    chk("xfer_completes", {31'b0, m_done}, 32'd1);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, 32'h0000_1004, HSIZE_WORD, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 3'b010, 4'b0000, 1, 2, 0};
    vecs[1] = '{1'b1, 32'h0000_0008, HSIZE_WORD, 32'h1234_5678, 32'h0, 3, 1'b0, 3'b001, 4'b1111, 4, 6, 0};
    vecs[2] = '{1'b1, 32'h0000_2003, HSIZE_BYTE, 32'hAABB_CCDD, 32'h0, 0, 1'b0, 3'b100, 4'b1000, 1, 3, 0};
    vecs[3] = '{1'b1, 32'h0000_1002, HSIZE_HALF, 32'h0000_BEEF, 32'h0, 0, 1'b0, 3'b010, 4'b1100, 1, 3, 0};
    vecs[4] = '{1'b1, 32'h0000_0001, HSIZE_BYTE, 32'h0000_1100, 32'h0, 1, 1'b0, 3'b001, 4'b0010, 2, 4, 0};
    vecs[5] = '{1'b1, 32'h0000_0000, HSIZE_HALF, 32'h0000_2222, 32'h0, 0, 1'b0, 3'b001, 4'b0011, 1, 3, 0};
    vecs[6] = '{1'b0, 32'h0000_2010, HSIZE_WORD, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 3'b100, 4'b0000, 1, 4, 2};
    vecs[7] = '{1'b0, 32'h0000_3000, HSIZE_WORD, 32'h0, 32'h0, 0, 1'b0, 3'b000, 4'b0000, 0, 2, 2};
    vecs[8] = '{1'b1, 32'h0000_0000, 3'd3,       32'h5, 32'h0, 0, 1'b0, 3'b000, 4'b0000, 0, 2, 2};
    vecs[9] = '{1'b0, 32'h0000_0100, HSIZE_WORD, 32'h0, 32'h55AA_1234, 2, 1'b0, 3'b001, 4'b0000, 3, 4, 0};

    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
    HTRANS = HTRANS_IDLE; HWDATA = '0; PRDATA = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    chk("rst_hresp",     {31'b0, HRESP},     32'd0);
    chk("rst_psel",      {29'b0, PSEL},      32'd0);
    chk("rst_penable",   {31'b0, PENABLE},   32'd0);
    chk("rst_hrdata",    HRDATA,             32'd0);
    chk("rst_paddr",     PADDR,              32'd0);
    chk("rst_pwdata",    PWDATA,             32'd0);
    chk("rst_pstrb",     {28'b0, PSTRB},     32'd0);
    chk("rst_pwrite",    {31'b0, PWRITE},    32'd0);
    HRESETn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_xfer(vecs[i]);
      chk($sformatf("v%0d_cycles", i), m_cyc,  vecs[i].e_cyc);
      chk($sformatf("v%0d_psel", i),   {29'b0, m_psel}, {29'b0, vecs[i].e_psel});
      chk($sformatf("v%0d_penable", i), m_pen, vecs[i].e_pen);
      chk($sformatf("v%0d_hresp", i),  m_resp, vecs[i].e_resp);
      if (vecs[i].e_pen > 0) begin
        chk($sformatf("v%0d_paddr", i),  m_paddr, vecs[i].addr);
        chk($sformatf("v%0d_pstrb", i),  {28'b0, m_pstrb}, {28'b0, vecs[i].e_strb});
        chk($sformatf("v%0d_stable", i), {31'b0, m_stable}, 32'd1);
        if (vecs[i].wr) chk($sformatf("v%0d_pwdata", i), m_pwdata, vecs[i].wdata);
      end
      if (!vecs[i].wr && vecs[i].e_resp == 0)
        chk($sformatf("v%0d_hrdata", i), m_hrdata, vecs[i].rdata);
    end

    // Back-to-back: write 0x1000 then read 0x2000 with no idle between them.
    begin
      int wdone, rsetup, rdone;
      logic pend;
      logic [31:0] wd, rd;
      logic [2:0] rsel;
      wdone = 0; rsetup = 0; rdone = 0; pend = 1'b0; wd = '0; rd = '0; rsel = '0;
      @(negedge HCLK);
      stalls_cfg = 0; slverr_cfg = 1'b0; PRDATA = 32'h0BAD_F00D;
      HSEL = 1'b1; HADDR = 32'h0000_1000; HWRITE = 1'b1; HSIZE = HSIZE_WORD; HTRANS = HTRANS_NONSEQ;
      @(posedge HCLK);
      @(negedge HCLK);
      HWDATA = 32'hA5A5_0001; HADDR = 32'h0000_2000; HWRITE = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        if (pend && HTRANS != HTRANS_IDLE) begin
          HTRANS = HTRANS_IDLE; HSEL = 1'b0;
        end
        if (PSEL != 0 && PENABLE && PREADY && PWRITE && wdone == 0) begin
          wdone = c; wd = PWDATA;
        end
        if (PSEL != 0 && !PENABLE && !PWRITE && rsetup == 0) begin
          rsetup = c; rsel = PSEL;
        end
        if (HREADYOUT && pend && rdone == 0) begin
          rdone = c; rd = HRDATA;
        end
        if (HREADYOUT && HTRANS == HTRANS_NONSEQ) pend = 1'b1;
        @(negedge HCLK);
      end
      chk("b2b_write_done", wdone, 3);
      chk("b2b_read_setup", rsetup, wdone + 1);
      chk("b2b_read_done",  rdone, 5);
      chk("b2b_pwdata",     wd, 32'hA5A5_0001);
      chk("b2b_read_psel",  {29'b0, rsel}, 32'd4);
      chk("b2b_hrdata",     rd, 32'h0BAD_F00D);
    end

    // Asynchronous reset while a stalled read sits in ACCESS.
    begin
      logic seen;
      seen = 1'b0;
      @(negedge HCLK);
      stalls_cfg = 5; PRDATA = 32'h1;
      HSEL = 1'b1; HADDR = 32'h0000_1000; HWRITE = 1'b0; HSIZE = HSIZE_WORD; HTRANS = HTRANS_NONSEQ;
      @(posedge HCLK);
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = HTRANS_IDLE;
      for (int c = 0; c < 10 && !seen; c++) begin
        if (PENABLE) seen = 1'b1;
        else @(negedge HCLK);
      end
      chk("rstmid_access_reached", {31'b0, seen}, 32'd1);
      #2 HRESETn = 1'b0;
      #1;
      chk("rstmid_psel",      {29'b0, PSEL},    32'd0);
      chk("rstmid_penable",   {31'b0, PENABLE}, 32'd0);
      chk("rstmid_hreadyout", {31'b0, HREADYOUT}, 32'd1);
      chk("rstmid_hresp",     {31'b0, HRESP},   32'd0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      run_xfer(vecs[0]);
      chk("post_rst_cycles", m_cyc, 2);
      chk("post_rst_psel",   {29'b0, m_psel}, 32'd2);
      chk("post_rst_hrdata", m_hrdata, 32'hCAFE_F00D);
    end

    repeat (2) @(negedge HCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
